// File: rtl/cfg_tx_if.sv
// ---------------------------------------------------------------------------
// cfg_tx_if
// Host beat bus into the config transmitter. The host drives the beat and the
// transmitter answers with a ready. A beat transfers on a clock edge where
// host_val and host_rdy are both high.
//
//   host_val   host -> tx   beat valid
//   host_dat   host -> tx   beat data (HOST_W bits, little-endian beat order)
//   host_last  host -> tx   final beat of a word
//   host_rdy   tx -> host   beat accepted when host_val & host_rdy
//
// Modports: master (host side), slave (transmitter side).
// ---------------------------------------------------------------------------
interface cfg_tx_if #(
    parameter int HOST_W = 16
) ();
    logic              host_val;
    logic [HOST_W-1:0] host_dat;
    logic              host_last;
    logic              host_rdy;

    modport master (
        output host_val,
        output host_dat,
        output host_last,
        input  host_rdy
    );

    modport slave (
        input  host_val,
        input  host_dat,
        input  host_last,
        output host_rdy
    );
endinterface

// File: rtl/cfg_tx.sv
// ---------------------------------------------------------------------------
// cfg_tx
// Transmit side of the per-layer config port. HOST_W-bit host beats are
// assembled into one DATA_W-bit layer schedule word, which is pushed into the
// config FIFO as a one-cycle IFCFG_Val strobe with the word on IFCFG. The FIFO
// has no ready, so the block keeps a credit count equal to the free FIFO
// entries; every Rst_Layer (FIFO pop) returns one credit, and a push is never
// issued without a credit.
//
// Ports:
//   clk        in   1         clock
//   rst_n      in   1         synchronous active-low reset
//   host       slave          host beat bus (cfg_tx_if: val/dat/last/rdy)
//   Rst_Layer  in   1         layer start / FIFO pop strobe, returns one credit
//   IFCFG_Val  out  1         one-cycle push strobe to the config FIFO
//   IFCFG      out  DATA_W    config word; holds the last pushed word otherwise
//   crd        out  CRD_W+1   free FIFO entries, 0..2**CRD_W
//   busy       out  1         a word is assembled and waiting to be pushed
//   err_frm    out  1         sticky framing error, cleared only by reset
//
// Build option:
//   CFG_TX_ZERO_CHK_EN  when defined, an assembled all-zero word is dropped
//                       and flagged on err_frm instead of being pushed.
// ---------------------------------------------------------------------------
module cfg_tx #(
    parameter int DATA_W = 64,
    parameter int HOST_W = 16,
    parameter int CRD_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    cfg_tx_if.slave           host,
    input  logic              Rst_Layer,
    output logic              IFCFG_Val,
    output logic [DATA_W-1:0] IFCFG,
    output logic [CRD_W:0]    crd,
    output logic              busy,
    output logic              err_frm
);

    localparam int NBEAT = (DATA_W + HOST_W - 1) / HOST_W;
    localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int WPAD  = NBEAT * HOST_W;
    localparam int DEPTH = 1 << CRD_W;

    localparam logic [CRD_W:0]   DEPTH_V  = (CRD_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEAT - 1);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        SEND     = 2'd1,
        WAIT_CRD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WPAD-1:0]   word_q, word_d, word_ins;
    logic [CRD_W:0]    crd_q, crd_d, crd_ap;
    logic              err_q, err_d;
    logic [DATA_W-1:0] ifcfg_q, ifcfg_d;
    logic              push;
    logic              accept;
    logic              crd_ret;

    // Ready is forced low while reset is asserted so no beat slips in.
    assign host.host_rdy = rst_n && (state_q == COLLECT);
    assign accept        = host.host_rdy && host.host_val;

    // A push needs a free FIFO entry; it is issued straight from SEND.
    assign push = (state_q == SEND) && (crd_q != '0);

    // Credit update: take the push first, then a pop can only return a
    // credit if the FIFO actually holds something after that push.
    assign crd_ap  = crd_q - {{CRD_W{1'b0}}, push};
    assign crd_ret = Rst_Layer && (crd_ap < DEPTH_V);
    assign crd_d   = crd_ap + {{CRD_W{1'b0}}, crd_ret};

    // Current beat written into its slot; bits beyond DATA_W in the last
    // beat land in padding that is never driven out.
    always_comb begin
        word_ins = word_q;
        for (int k = 0; k < NBEAT; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                word_ins[k*HOST_W +: HOST_W] = host.host_dat;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        err_d   = err_q;
        ifcfg_d = ifcfg_q;

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    word_d = word_ins;
                    if (host.host_last && (cnt_q == LAST_CNT)) begin
                        cnt_d = '0;
`ifdef CFG_TX_ZERO_CHK_EN
                        if (word_ins[DATA_W-1:0] == '0) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = SEND;
                        end
`else
                        state_d = SEND;
`endif
                    end else if (host.host_last || (cnt_q == LAST_CNT)) begin
                        // Early last or missing last: drop the partial word.
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (push) begin
                    ifcfg_d = word_q[DATA_W-1:0];
                    state_d = COLLECT;
                end else begin
                    state_d = WAIT_CRD;
                end
            end
            WAIT_CRD: begin
                // A credit returned this cycle lets the push go out next cycle.
                if (crd_d != '0) begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            crd_q   <= DEPTH_V;
            err_q   <= 1'b0;
            ifcfg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crd_q   <= crd_d;
            err_q   <= err_d;
            ifcfg_q <= ifcfg_d;
        end
    end

    // Assembly register needs no reset: the beat counter restarts at slot 0.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign IFCFG_Val = push;
    assign IFCFG     = push ? word_q[DATA_W-1:0] : ifcfg_q;
    assign crd       = crd_q;
    assign busy      = (state_q != COLLECT);
    assign err_frm   = err_q;

endmodule

// File: tb/tb_cfg_tx.sv
module tb_cfg_tx;

    localparam int DATA_W = 64;
    localparam int HOST_W = 16;
    localparam int CRD_W  = 3;
    localparam int DEPTH  = 8;
`ifdef CFG_TX_ZERO_CHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              Rst_Layer;
    logic              IFCFG_Val;
    logic [DATA_W-1:0] IFCFG;
    logic [CRD_W:0]    crd;
    logic              busy;
    logic              err_frm;

    cfg_tx_if #(.HOST_W(HOST_W)) hif ();

    cfg_tx #(
        .DATA_W(DATA_W),
        .HOST_W(HOST_W),
        .CRD_W (CRD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (hif),
        .Rst_Layer(Rst_Layer),
        .IFCFG_Val(IFCFG_Val),
        .IFCFG    (IFCFG),
        .crd      (crd),
        .busy     (busy),
        .err_frm  (err_frm)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO occupancy, words waiting for a credit, sticky error,
    // last word that reached the FIFO, and the scoreboard of pushes to expect.
    logic [63:0] exp_q[$];
    int          occ_m;
    int          pend_m;
    logic        err_m;
    logic [63:0] last_m;
    logic [63:0] pend_w;
    logic [63:0] mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every push must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && IFCFG_Val === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_push: got 0x%0h expected no push", IFCFG);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ifcfg_word", IFCFG, mon_e);
            end
        end
    end

    task automatic model_reset();
        occ_m  = 0;
        pend_m = 0;
        err_m  = 1'b0;
        last_m = '0;
        exp_q.delete();
    endtask

    task automatic model_issue(input logic [63:0] w, input int nb, input int last_at);
        if (!(nb == 4 && last_at == 3)) begin
            err_m = 1'b1;
        end else if (ZCHK && w == 64'd0) begin
            err_m = 1'b1;
        end else begin
            exp_q.push_back(w);
            if (occ_m < DEPTH) begin
                occ_m++;
                last_m = w;
            end else begin
                pend_m++;
                pend_w = w;
            end
        end
    endtask

    task automatic model_pop();
        if (occ_m > 0) occ_m--;
        if (pend_m > 0 && occ_m < DEPTH) begin
            pend_m--;
            occ_m++;
            last_m = pend_w;
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (hif.host_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (hif.host_rdy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL host_rdy_timeout: got rdy=%0b expected 1 within 50 cycles", hif.host_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [63:0] w, input int nb, input int last_at);
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                hif.host_val = 1'b0;
                sync();
            end
            hif.host_val  = 1'b1;
            hif.host_dat  = w[b*16 +: 16];
            hif.host_last = (b == last_at);
            wait_accept();
        end
        hif.host_val  = 1'b0;
        hif.host_last = 1'b0;
    endtask

    task automatic send(input logic [63:0] w, input int nb, input int last_at, input bit coincide);
        model_issue(w, nb, last_at);
        drive_word(w, nb, last_at);
        if (coincide) begin
            model_pop();
            Rst_Layer = 1'b1;
            sync();
            Rst_Layer = 1'b0;
        end
    endtask

    task automatic pulse_pop();
        model_pop();
        Rst_Layer = 1'b1;
        sync();
        Rst_Layer = 1'b0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        hif.host_val  = 1'b0;
        hif.host_last = 1'b0;
        Rst_Layer     = 1'b0;
        sync();
        @(negedge clk);
        chk("rdy_in_reset", {63'd0, hif.host_rdy}, 64'd0);
        sync();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_state(input string tag);
        repeat (3) sync();
        @(negedge clk);
        chk({tag, "_crd"},   {60'd0, crd}, 64'(DEPTH - occ_m));
        chk({tag, "_busy"},  {63'd0, busy}, {63'd0, (pend_m > 0)});
        chk({tag, "_rdy"},   {63'd0, hif.host_rdy}, {63'd0, (pend_m == 0)});
        chk({tag, "_err"},   {63'd0, err_frm}, {63'd0, err_m});
        chk({tag, "_hold"},  IFCFG, last_m);
        sync();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        int          r;

        hif.host_val  = 1'b0;
        hif.host_dat  = '0;
        hif.host_last = 1'b0;
        Rst_Layer     = 1'b0;
        rst_n         = 1'b0;

        // Reset state
        do_reset();
        check_state("reset");

        // Basic word and push latency
        model_issue(64'h4444_3333_2222_1111, 4, 3);
        drive_word(64'h4444_3333_2222_1111, 4, 3);
        @(negedge clk);
        chk("latency_val", {63'd0, IFCFG_Val}, 64'd1);
        chk("send_rdy", {63'd0, hif.host_rdy}, 64'd0);
        sync();
        check_state("basic");

        // Credit exhaustion: nine words, ninth waits for a credit
        do_reset();
        for (int i = 0; i < 9; i++) begin
            w = {$urandom, $urandom} | 64'd1;
            send(w, 4, 3, 1'b0);
        end
        check_state("exhaust");
        pulse_pop();
        @(negedge clk);
        chk("release_push", {63'd0, IFCFG_Val}, 64'd1);
        sync();
        check_state("release");

        // Framing: early last, then a good word still pushes
        do_reset();
        send(64'h0000_0000_BEEF_CAFE, 3, 2, 1'b0);
        check_state("early_last");
        send(64'h0123_4567_89AB_CDEF, 4, 3, 1'b0);
        check_state("after_err");
        // Framing: four beats without last
        send(64'hDEAD_0000_0000_0001, 4, -1, 1'b0);
        check_state("no_last");

        // Pop coincident with a push at crd=5
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send({$urandom, $urandom} | 64'd1, 4, 3, 1'b0);
        end
        check_state("crd5");
        send(64'hA5A5_5A5A_0F0F_F0F0, 4, 3, 1'b1);
        check_state("coincide");

        // Pop with an empty FIFO saturates
        do_reset();
        pulse_pop();
        check_state("saturate");

        // Reset in the middle of a word
        do_reset();
        drive_word(64'h0000_0000_7777_6666, 2, -1);
        do_reset();
        check_state("mid_reset");
        send(64'h1234_5678_9ABC_DEF0, 4, 3, 1'b0);
        check_state("post_reset");

        // All-zero word
        do_reset();
        send(64'd0, 4, 3, 1'b0);
        check_state("zero_word");

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (pend_m > 0 || r < 3) begin
                pulse_pop();
            end else if (r == 6) begin
                r = $urandom_range(0, 2);
                send({$urandom, $urandom}, r + 1, r, 1'b0);
            end else if (r == 7) begin
                send({$urandom, $urandom}, 4, -1, 1'b0);
            end else if (r == 8 && occ_m > 0 && occ_m < DEPTH) begin
                send({$urandom, $urandom}, 4, 3, 1'b1);
            end else begin
                send({$urandom, $urandom}, 4, 3, 1'b0);
            end
            check_state("rand");
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
